mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 if_req  in  1  fetch word request, held until if_done.
REQ-004 if_addr  in  32  fetch byte address.
REQ-005 if_rdata  out  32  fetched word, little-endian.
REQ-006 if_done  out  1  one-cycle completion pulse for fetch.
REQ-007 if_stall  out  1  fetch stall request.
REQ-008 mem_req  in  1  data access request (load/store ce), held until mem_done.
REQ-009 mem_we  in  1  1=store, 0=load.
REQ-010 mem_sel  in  4  store byte-lane enables; ignored for loads.
REQ-011 mem_addr  in  32  data byte address.
REQ-012 mem_wdata  in  32  store data, lane i = bits [8i+7:8i].
REQ-013 mem_rdata  out  32  loaded word, little-endian.
REQ-014 mem_done  out  1  one-cycle completion pulse for data access.
REQ-015 mem_stall  out  1  data-stage stall request.
REQ-016 ram_addr  out  32  byte address to single-port byte RAM.
REQ-017 ram_we  out  1  RAM byte write strobe.
REQ-018 ram_wdata  out  8  RAM write byte.
REQ-019 ram_rdata  in  8  RAM read byte, valid the cycle after ram_addr presented.

Function
REQ-020 States SHALL be IDLE, READ, WRITE, DONE; 3-bit lane counter cnt.
REQ-021 In IDLE, on a clock edge with mem_req=1, the block SHALL latch owner=MEM, base={mem_addr[31:2],2'b00}, we, sel, wdata and enter WRITE (mem_we=1) or READ (mem_we=0) with cnt=0.
REQ-022 In IDLE with mem_req=0 and if_req=1, the block SHALL latch owner=IF, base={if_addr[31:2],2'b00} and enter READ with cnt=0; MEM always wins simultaneous requests.
REQ-023 Address bits [1:0] SHALL be ignored; lane selection within the word is the requester's job.
REQ-024 READ: ram_addr=base+cnt for cnt 0..3, ram_we=0; on each edge with cnt=1..4, ram_rdata SHALL be captured into byte cnt-1 of the owner's rdata register; after cnt=4 go DONE (5 READ cycles).
REQ-025 WRITE: ram_addr=base+cnt, ram_wdata=wdata byte cnt, ram_we=sel[cnt] for cnt 0..3; after cnt=3 go DONE (4 WRITE cycles).
REQ-026 DONE: owner's done SHALL be 1 for exactly this one cycle, then IDLE; next arbitration occurs in IDLE, giving one idle cycle between transactions.
REQ-027 In IDLE and DONE, ram_addr=0, ram_we=0, ram_wdata=0.
REQ-028 if_stall = if_req & ~if_done; mem_stall = mem_req & ~mem_done (combinational).
REQ-029 if_rdata/mem_rdata SHALL change only while their owner's READ captures; otherwise hold.
REQ-030 A request dropped mid-transaction SHALL NOT abort it; transaction completes and done still pulses.
REQ-031 Inputs other than req SHALL be sampled only at the IDLE latch edge.
REQ-032 Load read latency: req high in IDLE -> done high 6 cycles later; store: 5 cycles.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, cnt=0, owner=IF, latched regs=0, if_rdata=mem_rdata=0, all done/ram outputs 0, from any state.
REQ-034 Reset mid-WRITE SHALL produce no further ram_we pulse after the reset edge.

Configuration
REQ-035 Macro ARB_WRITE_SKIP_EN defined: WRITE SHALL visit only lanes with sel set, ascending; cnt jumps to next set lane; sel=0000 goes IDLE->DONE via one WRITE cycle with ram_we=0; store latency = (number of set lanes, min 1)+1.
REQ-036 Macro undefined: WRITE SHALL always take 4 cycles per REQ-025.

Verification
REQ-037 RAM preloaded 0x100..0x103 = 11,22,33,44; if_req, if_addr=0x102 -> ram_addr 0x100..0x103, if_done 6 cycles later, if_rdata=0x44332211.
REQ-038 mem_req store, addr 0x200, sel=0100, wdata=0xAABBCCDD -> only 0x202 written with 0xBB; other bytes unchanged; mem_done after 5 cycles (2 with ARB_WRITE_SKIP_EN).
REQ-039 if_req and mem_req load asserted same cycle -> MEM served first, if_stall stays 1, IF served after the idle cycle; rdata values each correct.
REQ-040 rst pulsed in WRITE cycle cnt=1, sel=1111 -> ram_we 0 from next cycle, state IDLE, all outputs 0, no done pulse.
REQ-041 if_req dropped after 2 READ cycles -> transaction runs to DONE, if_done pulses, no RAM activity afterwards.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory arbiter and the byte-wide RAM.
// slave = arbiter side, master = requester/RAM side.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;

   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;

   logic [31:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_done, if_stall,
      input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
      output mem_rdata, mem_done, mem_stall,
      output ram_addr, ram_we, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_done, if_stall,
      output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
      input  mem_rdata, mem_done, mem_stall,
      input  ram_addr, ram_we, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data word accesses onto a single-port byte RAM, one byte per cycle.
// Optional macro ARB_WRITE_SKIP_EN: stores visit only the byte lanes whose sel bit is set.
module mem_arbiter (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic [31:0] base_q, base_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic [1:0]  lane;
   logic [7:0]  wdata_lane [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata_lane[gi] = wdata_q[8*gi +: 8];
      end
   endgenerate

`ifdef ARB_WRITE_SKIP_EN
   // Lowest set lane at or above 'from'; 4 means no lane left.
   function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] from);
      logic [2:0] res;
      res = 3'd4;
      for (int i = 3; i >= 0; i--) begin
         if (sel[i] && (3'(i) >= from)) res = 3'(i);
      end
      return res;
   endfunction

   logic [2:0] first_lane;
   logic [2:0] following_lane;
   assign first_lane     = next_lane(bus.mem_sel, 3'd0);
   assign following_lane = next_lane(sel_q, cnt_q + 3'd1);
`endif

   // Byte lane captured on this edge is the one addressed in the previous cycle.
   assign lane = cnt_q[1:0] - 2'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      base_d      = base_q;
      we_d        = we_q;
      sel_d       = sel_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               owner_d = OWN_MEM;
               base_d  = {bus.mem_addr[31:2], 2'b00};
               we_d    = bus.mem_we;
               sel_d   = bus.mem_sel;
               wdata_d = bus.mem_wdata;
               cnt_d   = 3'd0;
               state_d = bus.mem_we ? WRITE : READ;
`ifdef ARB_WRITE_SKIP_EN
               if (bus.mem_we && (first_lane != 3'd4)) cnt_d = first_lane;
`endif
            end else if (bus.if_req) begin
               owner_d = OWN_IF;
               base_d  = {bus.if_addr[31:2], 2'b00};
               we_d    = 1'b0;
               cnt_d   = 3'd0;
               state_d = READ;
            end
         end
         READ: begin
            if (cnt_q != 3'd0) begin
               if (owner_q == OWN_MEM) mem_rdata_d[{lane, 3'b000} +: 8] = bus.ram_rdata;
               else                    if_rdata_d[{lane, 3'b000} +: 8]  = bus.ram_rdata;
            end
            if (cnt_q == 3'd4) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         WRITE: begin
`ifdef ARB_WRITE_SKIP_EN
            if (following_lane == 3'd4) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = following_lane;
            end
`else
            if (cnt_q == 3'd3) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         owner_q     <= OWN_IF;
         base_q      <= 32'd0;
         we_q        <= 1'b0;
         sel_q       <= 4'd0;
         wdata_q     <= 32'd0;
         if_rdata_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // The cnt=4 READ cycle only collects the last byte, so the RAM bus is parked then.
   assign bus.ram_addr  = ((state_q == WRITE) || ((state_q == READ) && (cnt_q != 3'd4)))
                          ? {base_q[31:2], cnt_q[1:0]} : 32'd0;
   assign bus.ram_we    = (state_q == WRITE) && sel_q[cnt_q[1:0]];
   assign bus.ram_wdata = (state_q == WRITE) ? wdata_lane[cnt_q[1:0]] : 8'd0;

   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.if_done   = (state_q == DONE) && (owner_q == OWN_IF);
   assign bus.mem_done  = (state_q == DONE) && (owner_q == OWN_MEM);
   assign bus.if_stall  = bus.if_req & ~bus.if_done;
   assign bus.mem_stall = bus.mem_req & ~bus.mem_done;

   logic unused_bits;
   assign unused_bits = ^{bus.if_addr[1:0], bus.mem_addr[1:0], base_q[1:0], we_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read byte RAM model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef ARB_WRITE_SKIP_EN
   localparam int SEL1_LAT = 2;
`else
   localparam int SEL1_LAT = 5;
`endif

   // RAM model: clear, backdoor preload, byte write, read data valid the next cycle.
   logic [7:0]  ram [0:2047];
   logic [7:0]  ram_rdata_q;
   logic        clr;
   logic        pl_en;
   logic [10:0] pl_addr;
   logic [7:0]  pl_data;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 2048; i++) ram[i] <= 8'h00;
      end else begin
         if (bus.ram_we) ram[bus.ram_addr[10:0]] <= bus.ram_wdata;
         if (pl_en)      ram[pl_addr] <= pl_data;
      end
      ram_rdata_q <= ram[bus.ram_addr[10:0]];
   end
   assign bus.ram_rdata = ram_rdata_q;

   int wr_count = 0;
   int if_done_cnt = 0;
   int mem_done_cnt = 0;
   int ram_busy = 0;
   always @(posedge clk) begin
      if (bus.ram_we) wr_count <= wr_count + 1;
      if (bus.if_done) if_done_cnt <= if_done_cnt + 1;
      if (bus.mem_done) mem_done_cnt <= mem_done_cnt + 1;
      if ((bus.ram_addr != 32'd0) || bus.ram_we) ram_busy <= ram_busy + 1;
   end

   int checks = 0;
   int failures = 0;
   logic [31:0] addr_log [0:31];

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [10:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick;
      pl_en = 1'b0;
   endtask

   // Issue one request, log ram_addr each cycle, return cycles from latch edge to done.
   task automatic run_txn(input bit is_mem, input bit we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, output int lat);
      if (is_mem) begin
         bus.mem_req = 1'b1;
         bus.mem_we = we;
         bus.mem_sel = sel;
         bus.mem_addr = addr;
         bus.mem_wdata = wdata;
      end else begin
         bus.if_req = 1'b1;
         bus.if_addr = addr;
      end
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         tick;
         addr_log[n] = bus.ram_addr;
         if (is_mem ? bus.mem_done : bus.if_done) begin
            lat = n;
            break;
         end
      end
      bus.mem_req = 1'b0;
      bus.if_req = 1'b0;
      tick;
      $display("txn %s we=%0d sel=%b addr=%h wdata=%h latency=%0d",
               is_mem ? "mem" : "if", we, sel, addr, wdata, lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int lat, mem_lat, if_lat, w0, b0, d0;

   initial begin
      bus.if_req = 1'b0;
      bus.if_addr = 32'd0;
      bus.mem_req = 1'b0;
      bus.mem_we = 1'b0;
      bus.mem_sel = 4'd0;
      bus.mem_addr = 32'd0;
      bus.mem_wdata = 32'd0;
      rst = 1'b1;
      clr = 1'b1;
      pl_en = 1'b0;
      pl_addr = 11'd0;
      pl_data = 8'd0;
      tick;
      clr = 1'b0;
      preload(11'h100, 8'h11); preload(11'h101, 8'h22);
      preload(11'h102, 8'h33); preload(11'h103, 8'h44);
      preload(11'h200, 8'h01); preload(11'h201, 8'h02);
      preload(11'h202, 8'h03); preload(11'h203, 8'h04);
      preload(11'h300, 8'h55); preload(11'h301, 8'h66);
      preload(11'h302, 8'h77); preload(11'h303, 8'h88);
      tick;

      // Reset state
      chk("rst_if_done", 32'(bus.if_done), 32'd0);
      chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
      chk("rst_ram_addr", bus.ram_addr, 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
      rst = 1'b0;
      tick;

      // Fetch of an unaligned address reads the whole aligned word
      run_txn(1'b0, 1'b0, 4'd0, 32'h102, 32'd0, lat);
      chk("fetch_latency", lat, 6);
      chk("fetch_addr0", addr_log[1], 32'h100);
      chk("fetch_addr1", addr_log[2], 32'h101);
      chk("fetch_addr2", addr_log[3], 32'h102);
      chk("fetch_addr3", addr_log[4], 32'h103);
      chk("fetch_rdata", bus.if_rdata, 32'h44332211);
      chk("fetch_mem_rdata_hold", bus.mem_rdata, 32'd0);
      chk("fetch_idle_ram_addr", bus.ram_addr, 32'd0);

      // Single-lane store
      w0 = wr_count;
      run_txn(1'b1, 1'b1, 4'b0100, 32'h200, 32'hAABBCCDD, lat);
      chk("store1_latency", lat, SEL1_LAT);
      chk("store1_writes", wr_count - w0, 1);
      chk("store1_word", {ram[11'h203], ram[11'h202], ram[11'h201], ram[11'h200]}, 32'h04BB0201);
      chk("store1_mem_rdata_hold", bus.mem_rdata, 32'd0);

      // Full-word store then load back
      w0 = wr_count;
      run_txn(1'b1, 1'b1, 4'b1111, 32'h400, 32'h12345678, lat);
      chk("store4_latency", lat, 5);
      chk("store4_writes", wr_count - w0, 4);
      chk("store4_addr3", addr_log[4], 32'h403);
      run_txn(1'b1, 1'b0, 4'b0000, 32'h403, 32'd0, lat);
      chk("load_latency", lat, 6);
      chk("load_rdata", bus.mem_rdata, 32'h12345678);
      chk("load_if_rdata_hold", bus.if_rdata, 32'h44332211);

      // Simultaneous requests: MEM first, IF after the idle cycle
      bus.mem_req = 1'b1;
      bus.mem_we = 1'b0;
      bus.mem_sel = 4'b1111;
      bus.mem_addr = 32'h301;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h203;
      #1;
      chk("arb_if_stall_start", 32'(bus.if_stall), 32'd1);
      chk("arb_mem_stall_start", 32'(bus.mem_stall), 32'd1);
      mem_lat = -1;
      if_lat = -1;
      for (int n = 1; n <= 30; n++) begin
         tick;
         if (n == mem_lat + 1) chk("arb_if_stall_idle", 32'(bus.if_stall), 32'd1);
         if (bus.mem_done) begin
            mem_lat = n;
            chk("arb_if_rdata_hold", bus.if_rdata, 32'h44332211);
            chk("arb_if_no_done", 32'(bus.if_done), 32'd0);
            bus.mem_req = 1'b0;
         end
         if (bus.if_done) begin
            if_lat = n;
            break;
         end
      end
      bus.if_req = 1'b0;
      tick;
      $display("txn arb mem_lat=%0d if_lat=%0d", mem_lat, if_lat);
      chk("arb_mem_latency", mem_lat, 6);
      chk("arb_if_latency", if_lat, 13);
      chk("arb_mem_rdata", bus.mem_rdata, 32'h88776655);
      chk("arb_if_rdata", bus.if_rdata, 32'h04BB0201);

      // Fetch request dropped mid-transaction still completes
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         tick;
         if (n == 2) bus.if_req = 1'b0;
         if (bus.if_done) begin
            lat = n;
            break;
         end
      end
      tick;
      $display("txn if drop addr=%h latency=%0d", 32'h100, lat);
      chk("drop_latency", lat, 6);
      chk("drop_rdata", bus.if_rdata, 32'h44332211);
      chk("drop_if_stall", 32'(bus.if_stall), 32'd0);
      b0 = ram_busy;
      d0 = if_done_cnt + mem_done_cnt;
      repeat (5) tick;
      chk("drop_no_ram_activity", ram_busy - b0, 0);
      chk("drop_no_extra_done", if_done_cnt + mem_done_cnt - d0, 0);

      // Reset in the middle of a full-word store
      w0 = wr_count;
      d0 = if_done_cnt + mem_done_cnt;
      bus.mem_req = 1'b1;
      bus.mem_we = 1'b1;
      bus.mem_sel = 4'b1111;
      bus.mem_addr = 32'h500;
      bus.mem_wdata = 32'hCAFEF00D;
      tick;
      tick;
      chk("rstw_we_before", 32'(bus.ram_we), 32'd1);
      chk("rstw_addr_before", bus.ram_addr, 32'h501);
      rst = 1'b1;
      bus.mem_req = 1'b0;
      tick;
      chk("rstw_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rstw_ram_addr", bus.ram_addr, 32'd0);
      chk("rstw_ram_wdata", 32'(bus.ram_wdata), 32'd0);
      chk("rstw_if_rdata", bus.if_rdata, 32'd0);
      chk("rstw_mem_rdata", bus.mem_rdata, 32'd0);
      rst = 1'b0;
      repeat (6) tick;
      $display("txn mem store reset-abort addr=%h writes=%0d", 32'h500, wr_count - w0);
      chk("rstw_writes", wr_count - w0, 2);
      chk("rstw_no_done", if_done_cnt + mem_done_cnt - d0, 0);
      chk("rstw_bytes", {ram[11'h503], ram[11'h502], ram[11'h501], ram[11'h500]}, 32'h0000F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
